// File: rtl/tag_frame_decoder_if.sv
// Bit-stream inputs and decoded-frame outputs of the backscatter tag frame decoder.
// The bench drives through master and the decoder sits on slave.
interface tag_frame_decoder_if;
    logic        sof;
    logic        bit_valid;
    logic        bit_tx;
    logic        bit_rx;
    logic        abort;
    logic        busy;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic [5:0]  byte_index;
    logic [7:0]  rss;
    logic [95:0] tag_id;
    logic        frame_done;
    logic        crc_ok;
    logic        zero_err;

    modport master (
        output sof, bit_valid, bit_tx, bit_rx, abort,
        input  busy, byte_valid, byte_data, byte_index, rss, tag_id,
               frame_done, crc_ok, zero_err
    );

    modport slave (
        input  sof, bit_valid, bit_tx, bit_rx, abort,
        output busy, byte_valid, byte_data, byte_index, rss, tag_id,
               frame_done, crc_ok, zero_err
    );
endinterface

// File: rtl/tag_frame_decoder.sv
// Recovers the tag bit stream (tx XOR rx), walks SKIP/DATA/FCS, emits data bytes LSB-first,
// checks the CRC-32 FCS and captures the RSS byte and the 12-byte tag ID.
module tag_frame_decoder #(
    parameter int SKIP_BITS  = 32,
    parameter int DATA_BYTES = 60,
    parameter int RSS_OFFSET = 22,
    parameter int ID_OFFSET  = 34,
    parameter int ID_LEN     = 12
) (
    input logic             clk,
    input logic             reset,
    tag_frame_decoder_if.slave bus
);
    localparam logic [8:0]  SKIP_LAST = 9'(SKIP_BITS - 1);
    localparam logic [8:0]  DATA_LAST = 9'(8 * DATA_BYTES - 1);
    localparam logic [8:0]  FCS_LAST  = 9'd31;
    localparam logic [31:0] CRC_POLY  = 32'h04C11DB7;

    if (DATA_BYTES > 64 || DATA_BYTES < 1 || ID_LEN != 12 || ID_OFFSET + ID_LEN > DATA_BYTES ||
        RSS_OFFSET >= DATA_BYTES || SKIP_BITS < 1 || SKIP_BITS > 512) begin : g_param_check
        $error("tag_frame_decoder: illegal parameter set");
    end

    typedef enum logic [1:0] {IDLE, SKIP, DATA, FCS} state_t;

    state_t      state_reg;
    logic [8:0]  bit_cnt_reg;
    logic [31:0] crc_reg;
    logic [31:0] exp_fcs_reg;
    logic [31:0] rx_fcs_reg;
    logic [7:0]  byte_sr_reg;
    logic [7:0]  byte_data_reg;
    logic [5:0]  byte_index_reg;
    logic        byte_valid_reg;
    logic        frame_done_reg;
    logic        crc_ok_reg;
    logic        zero_err_reg;
    logic [7:0]  rss_reg;

    logic        d;
    logic        fb;
    logic [31:0] crc_next;
    logic [31:0] rx_fcs_next;
    logic [7:0]  cur_byte;
    logic [5:0]  cur_index;
    logic        byte_end;

    always_comb begin
        d           = bus.bit_tx ^ bus.bit_rx;
        fb          = crc_reg[31] ^ d;
        crc_next    = {crc_reg[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
        rx_fcs_next = {rx_fcs_reg[30:0], d};
        cur_byte    = {d, byte_sr_reg[7:1]};
        cur_index   = bit_cnt_reg[8:3];
        // sof and abort both pre-empt the byte that would otherwise complete this cycle
        byte_end    = !bus.sof && !bus.abort && bus.bit_valid &&
                      (state_reg == DATA) && (bit_cnt_reg[2:0] == 3'd7);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            bit_cnt_reg    <= '0;
            crc_reg        <= '0;
            exp_fcs_reg    <= '0;
            rx_fcs_reg     <= '0;
            byte_sr_reg    <= '0;
            byte_data_reg  <= '0;
            byte_index_reg <= '0;
            byte_valid_reg <= 1'b0;
            frame_done_reg <= 1'b0;
            crc_ok_reg     <= 1'b0;
            zero_err_reg   <= 1'b0;
            rss_reg        <= '0;
        end else begin
            byte_valid_reg <= 1'b0;
            frame_done_reg <= 1'b0;
            if (bus.sof) begin
                state_reg    <= SKIP;
                bit_cnt_reg  <= '0;
                crc_reg      <= 32'hFFFF_FFFF;
                crc_ok_reg   <= 1'b0;
                zero_err_reg <= 1'b0;
                rss_reg      <= '0;
                if (bus.bit_valid) begin
                    zero_err_reg <= d;
                    if (SKIP_LAST == 9'd0) state_reg <= DATA;
                    else                   bit_cnt_reg <= 9'd1;
                end
            end else if (bus.abort && state_reg != IDLE) begin
                state_reg   <= IDLE;
                bit_cnt_reg <= '0;
            end else if (bus.bit_valid) begin
                case (state_reg)
                    SKIP: begin
                        if (d) zero_err_reg <= 1'b1;
                        if (bit_cnt_reg == SKIP_LAST) begin
                            state_reg   <= DATA;
                            bit_cnt_reg <= '0;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 9'd1;
                        end
                    end
                    DATA: begin
                        byte_sr_reg <= cur_byte;
                        crc_reg     <= crc_next;
                        if (byte_end) begin
                            byte_valid_reg <= 1'b1;
                            byte_data_reg  <= cur_byte;
                            byte_index_reg <= cur_index;
                            if (cur_index == 6'(RSS_OFFSET)) rss_reg <= cur_byte;
                        end
                        if (bit_cnt_reg == DATA_LAST) begin
                            exp_fcs_reg <= ~crc_next;
                            state_reg   <= FCS;
                            bit_cnt_reg <= '0;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 9'd1;
                        end
                    end
                    FCS: begin
                        rx_fcs_reg <= rx_fcs_next;
                        if (bit_cnt_reg == FCS_LAST) begin
                            frame_done_reg <= 1'b1;
                            crc_ok_reg     <= (rx_fcs_next == exp_fcs_reg);
                            state_reg      <= IDLE;
                            bit_cnt_reg    <= '0;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 9'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Each tag-ID byte owns its register; the first ID byte lands in the top of tag_id.
    wire [95:0] tag_id_w;
    for (genvar gi = 0; gi < ID_LEN; gi++) begin : g_id
        logic [7:0] id_byte_reg;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                id_byte_reg <= '0;
            end else if (bus.sof) begin
                id_byte_reg <= '0;
            end else if (byte_end && cur_index == 6'(ID_OFFSET + gi)) begin
                id_byte_reg <= cur_byte;
            end
        end
        assign tag_id_w[95 - 8 * gi -: 8] = id_byte_reg;
    end

    assign bus.busy       = (state_reg != IDLE);
    assign bus.byte_valid = byte_valid_reg;
    assign bus.byte_data  = byte_data_reg;
    assign bus.byte_index = byte_index_reg;
    assign bus.rss        = rss_reg;
    assign bus.tag_id     = tag_id_w;
    assign bus.frame_done = frame_done_reg;
    assign bus.crc_ok     = crc_ok_reg;
    assign bus.zero_err   = zero_err_reg;
endmodule

// File: tb/tb_tag_frame_decoder.sv
// Randomized frame-level bench: builds tag frames, sends them as tx/rx bit pairs and
// compares decoded bytes, fields and status against a frame model.
module tb_tag_frame_decoder;
    localparam int SKIP_BITS  = 32;
    localparam int DATA_BYTES = 60;
    localparam int RSS_OFFSET = 22;
    localparam int ID_OFFSET  = 34;
    localparam int ID_LEN     = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tag_frame_decoder_if bus ();

    tag_frame_decoder #(
        .SKIP_BITS (SKIP_BITS),
        .DATA_BYTES(DATA_BYTES),
        .RSS_OFFSET(RSS_OFFSET),
        .ID_OFFSET (ID_OFFSET),
        .ID_LEN    (ID_LEN)
    ) dut (
        .clk  (clk),
        .reset(rst_n),
        .bus  (bus)
    );

    int n_compared = 0;
    int n_mismatched = 0;
    int bytes_seen = 0;
    int done_seen = 0;
    logic [13:0] exp_q[$];
    logic [7:0]  frame_bytes[DATA_BYTES];
    logic [95:0] exp_tag_id;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Byte-stream monitor: every byte_valid must match the next byte the model expects.
    always @(negedge clk) begin
        if (rst_n && bus.byte_valid) begin
            logic [13:0] e;
            bytes_seen++;
            if (exp_q.size() == 0) begin
                check("byte_unexpected", 96'd1, 96'd0);
            end else begin
                e = exp_q.pop_front();
                check("byte_index", {90'd0, bus.byte_index}, {90'd0, e[13:8]});
                check("byte_data", {88'd0, bus.byte_data}, {88'd0, e[7:0]});
            end
        end
        if (rst_n && bus.frame_done) done_seen++;
    end

    function automatic int gap();
        return int'($urandom_range(0, 2));
    endfunction

    task automatic fill_frame();
        string s_tag = "LOCTAG-10000";
        string s_key = "000000-00000";
        for (int b = 0; b < DATA_BYTES; b++) frame_bytes[b] = 8'($urandom);
        frame_bytes[RSS_OFFSET] = 8'h5A;
        exp_tag_id = '0;
        for (int i = 0; i < ID_LEN; i++) begin
            frame_bytes[ID_OFFSET + i] = s_tag[i] ^ s_key[i];
            exp_tag_id[95 - 8 * i -: 8] = s_tag[i] ^ s_key[i];
        end
    endtask

    // FCS over the data bits in transmission order (byte 0 first, each byte LSB-first).
    function automatic logic [31:0] model_fcs();
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        for (int b = 0; b < DATA_BYTES; b++) begin
            for (int k = 0; k < 8; k++) begin
                fb = c[31] ^ frame_bytes[b][k];
                c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
            end
        end
        return ~c;
    endfunction

    task automatic put_bit(input logic tag_bit, input logic with_sof, input int n_gap);
        logic tx;
        tx = 1'($urandom_range(0, 1));
        bus.bit_tx    = tx;
        bus.bit_rx    = tx ^ tag_bit;
        bus.bit_valid = 1'b1;
        bus.sof       = with_sof;
        @(posedge clk); #1;
        bus.bit_valid = 1'b0;
        bus.sof       = 1'b0;
        repeat (n_gap) begin
            bus.bit_tx = 1'($urandom_range(0, 1));
            bus.bit_rx = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
    endtask

    // stop_byte < 0 sends the whole frame (with fcs_bits FCS bits); otherwise stops after that byte.
    task automatic run_frame(input int skip_err_pos, input bit flip_fcs, input int stop_byte,
                             input int fcs_bits);
        logic [31:0] fcs;
        int          n_bytes;
        bit          sep;
        fill_frame();
        fcs = model_fcs();
        if (flip_fcs) fcs[0] = ~fcs[0];
        sep = 1'($urandom_range(0, 1));
        if (sep) begin
            bus.sof = 1'b1;
            @(posedge clk); #1;
            bus.sof = 1'b0;
        end
        for (int i = 0; i < SKIP_BITS; i++)
            put_bit(i == skip_err_pos, !sep && i == 0, gap());
        n_bytes = (stop_byte < 0) ? DATA_BYTES : stop_byte + 1;
        for (int b = 0; b < n_bytes; b++) begin
            for (int k = 0; k < 8; k++) begin
                if (k == 7) exp_q.push_back({6'(b), frame_bytes[b]});
                put_bit(frame_bytes[b][k], 1'b0, gap());
            end
        end
        if (stop_byte < 0)
            for (int j = 0; j < fcs_bits; j++) put_bit(fcs[31 - j], 1'b0, gap());
    endtask

    task automatic check_frame(input string name, input int done0, input int bytes0,
                               input int exp_done, input int exp_bytes, input logic exp_crc,
                               input logic exp_zero);
        repeat (4) @(posedge clk);
        #1;
        $display("frame %s: done=%0d bytes=%0d crc_ok=%0b zero_err=%0b rss=%0h", name,
                 done_seen - done0, bytes_seen - bytes0, bus.crc_ok, bus.zero_err, bus.rss);
        check({name, "_done_count"}, 96'(done_seen - done0), 96'(exp_done));
        check({name, "_byte_count"}, 96'(bytes_seen - bytes0), 96'(exp_bytes));
        check({name, "_queue_left"}, 96'(exp_q.size()), 96'd0);
        check({name, "_crc_ok"}, {95'd0, bus.crc_ok}, {95'd0, exp_crc});
        check({name, "_zero_err"}, {95'd0, bus.zero_err}, {95'd0, exp_zero});
        check({name, "_rss"}, {88'd0, bus.rss}, 96'h5A);
        check({name, "_tag_id"}, bus.tag_id, exp_tag_id);
        check({name, "_busy"}, {95'd0, bus.busy}, 96'd0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_busy"}, {95'd0, bus.busy}, 96'd0);
        check({name, "_byte_valid"}, {95'd0, bus.byte_valid}, 96'd0);
        check({name, "_byte_data"}, {88'd0, bus.byte_data}, 96'd0);
        check({name, "_byte_index"}, {90'd0, bus.byte_index}, 96'd0);
        check({name, "_rss"}, {88'd0, bus.rss}, 96'd0);
        check({name, "_tag_id"}, bus.tag_id, 96'd0);
        check({name, "_frame_done"}, {95'd0, bus.frame_done}, 96'd0);
        check({name, "_crc_ok"}, {95'd0, bus.crc_ok}, 96'd0);
        check({name, "_zero_err"}, {95'd0, bus.zero_err}, 96'd0);
    endtask

    initial begin
        int d0;
        int b0;
        bus.sof = 1'b0; bus.bit_valid = 1'b0; bus.bit_tx = 1'b0; bus.bit_rx = 1'b0;
        bus.abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // abort in IDLE is ignored
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        check("idle_abort_busy", {95'd0, bus.busy}, 96'd0);

        for (int r = 0; r < 2; r++) begin
            d0 = done_seen; b0 = bytes_seen;
            run_frame(-1, 1'b0, -1, 32);
            check_frame("clean", d0, b0, 1, DATA_BYTES, 1'b1, 1'b0);
        end

        d0 = done_seen; b0 = bytes_seen;
        run_frame(-1, 1'b1, -1, 32);
        check_frame("fcs_flip", d0, b0, 1, DATA_BYTES, 1'b0, 1'b0);

        d0 = done_seen; b0 = bytes_seen;
        run_frame(int'($urandom_range(0, SKIP_BITS - 1)), 1'b0, -1, 32);
        check_frame("skip_err", d0, b0, 1, DATA_BYTES, 1'b1, 1'b1);

        // abort after byte 30
        d0 = done_seen; b0 = bytes_seen;
        run_frame(-1, 1'b0, 30, 32);
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        check("abort_busy_next", {95'd0, bus.busy}, 96'd0);
        repeat (4) @(posedge clk);
        #1;
        $display("abort: done=%0d bytes=%0d", done_seen - d0, bytes_seen - b0);
        check("abort_done_count", 96'(done_seen - d0), 96'd0);
        check("abort_byte_count", 96'(bytes_seen - b0), 96'd31);
        check("abort_crc_ok", {95'd0, bus.crc_ok}, 96'd0);
        check("abort_rss_kept", {88'd0, bus.rss}, 96'h5A);
        d0 = done_seen; b0 = bytes_seen;
        run_frame(-1, 1'b0, -1, 32);
        check_frame("after_abort", d0, b0, 1, DATA_BYTES, 1'b1, 1'b0);

        // sof re-asserted at byte 10 of a frame
        d0 = done_seen; b0 = bytes_seen;
        run_frame(-1, 1'b0, 9, 32);
        run_frame(-1, 1'b0, -1, 32);
        check_frame("restart", d0, b0, 1, DATA_BYTES + 10, 1'b1, 1'b0);

        // reset pulsed during the FCS section
        d0 = done_seen;
        run_frame(-1, 1'b0, -1, 10);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        exp_q.delete();
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        $display("mid_reset: done=%0d", done_seen - d0);
        check("mid_reset_done_count", 96'(done_seen - d0), 96'd0);
        d0 = done_seen; b0 = bytes_seen;
        run_frame(-1, 1'b0, -1, 32);
        check_frame("after_reset", d0, b0, 1, DATA_BYTES, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end
endmodule
